// File: rtl/perf_monitor_unit.sv
// Performance monitor: event/cycle counters, snapshot readout, halt-driven drain.
// Define PMU_WRAP_EN to make counters wrap instead of saturating.
module perf_monitor_unit #(
    parameter int NUM_EVENTS = 6,
    parameter int CNT_W      = 32,
    parameter int PIPE_DEPTH = 5,
    localparam int SEL_W     = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clear,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  halt_seen,
    input  logic                  snap_req,
    output logic                  snap_valid,
    input  logic                  rd_ack,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic [CNT_W-1:0]      rd_data,
    output logic                  rd_ovf,
    output logic [1:0]            state,
    output logic                  done
);

    localparam int NC = NUM_EVENTS + 1;
    localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_COUNT = 2'b01,
        S_DRAIN = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DW-1:0]    r_drain;
    logic [DW-1:0]    w_drain_nxt;
    logic             w_enter_done;
    logic             w_counting;
    logic             r_snap_valid;

    logic [CNT_W-1:0] r_cnt     [NC];
    logic [CNT_W-1:0] w_cnt_nxt [NC];
    logic [CNT_W-1:0] r_shd     [NC];
    logic [NC-1:0]    r_ovf;
    logic [NC-1:0]    w_ovf_nxt;
    logic [NC-1:0]    r_shd_ovf;
    logic [NC-1:0]    w_evt;

    // Top bit is the cycle counter, which "sees" an event every cycle.
    assign w_evt      = {1'b1, event_in};
    assign w_counting = (r_state == S_COUNT) || (r_state == S_DRAIN);

    always_comb begin
        for (int i = 0; i < NC; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            w_ovf_nxt[i] = r_ovf[i];
            if (w_counting && w_evt[i]) begin
                if (&r_cnt[i]) begin
                    w_ovf_nxt[i] = 1'b1;
`ifdef PMU_WRAP_EN
                    w_cnt_nxt[i] = '0;
`else
                    w_cnt_nxt[i] = r_cnt[i];
`endif
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_drain_nxt  = r_drain;
        w_enter_done = 1'b0;
        if (clear) begin
            if (r_state == S_DONE) w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) w_state_nxt = S_COUNT;
                end
                S_COUNT: begin
                    if (halt_seen) begin
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = DW'(PIPE_DEPTH - 1);
                    end
                end
                S_DRAIN: begin
                    if (r_drain == '0) begin
                        w_state_nxt  = S_DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_drain_nxt = r_drain - 1'b1;
                    end
                end
                S_DONE: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_drain      <= '0;
            r_snap_valid <= 1'b0;
            r_ovf        <= '0;
            r_shd_ovf    <= '0;
            for (int i = 0; i < NC; i++) begin
                r_cnt[i] <= '0;
                r_shd[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_drain <= w_drain_nxt;
            if (clear) begin
                r_snap_valid <= 1'b0;
                r_ovf        <= '0;
                r_shd_ovf    <= '0;
                for (int i = 0; i < NC; i++) begin
                    r_cnt[i] <= '0;
                    r_shd[i] <= '0;
                end
            end else begin
                r_ovf <= w_ovf_nxt;
                for (int i = 0; i < NC; i++) r_cnt[i] <= w_cnt_nxt[i];
                // Auto-snapshot on DONE entry captures the final, frozen values.
                if (rd_ack) begin
                    r_snap_valid <= 1'b0;
                end else if (!r_snap_valid && w_enter_done) begin
                    r_snap_valid <= 1'b1;
                    r_shd_ovf    <= w_ovf_nxt;
                    for (int i = 0; i < NC; i++) r_shd[i] <= w_cnt_nxt[i];
                end else if (!r_snap_valid && snap_req) begin
                    r_snap_valid <= 1'b1;
                    r_shd_ovf    <= r_ovf;
                    for (int i = 0; i < NC; i++) r_shd[i] <= r_cnt[i];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_ovf  = 1'b0;
        for (int i = 0; i < NC; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_data = r_shd[i];
                rd_ovf  = r_shd_ovf[i];
            end
        end
    end

    assign snap_valid = r_snap_valid;
    assign state      = r_state;
    assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_perf_monitor_unit.sv
// Self-checking bench for perf_monitor_unit: directed cases plus random traffic
// compared every cycle against a behavioural model.
module tb_perf_monitor_unit;

    localparam int NE   = 6;
    localparam int CW   = 8;
    localparam int PD   = 5;
    localparam int SW   = $clog2(NE + 1);
    localparam int NC   = NE + 1;
    localparam int MAXV = (1 << CW) - 1;
`ifdef PMU_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [NE-1:0] event_in = '0;
    logic          halt_seen = 1'b0;
    logic          snap_req = 1'b0;
    logic          rd_ack = 1'b0;
    logic [SW-1:0] rd_sel = '0;
    logic          snap_valid;
    logic [CW-1:0] rd_data;
    logic          rd_ovf;
    logic [1:0]    state;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;
    bit en_cmp   = 1'b0;

    perf_monitor_unit #(.NUM_EVENTS(NE), .CNT_W(CW), .PIPE_DEPTH(PD)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .event_in(event_in), .halt_seen(halt_seen), .snap_req(snap_req),
        .snap_valid(snap_valid), .rd_ack(rd_ack), .rd_sel(rd_sel),
        .rd_data(rd_data), .rd_ovf(rd_ovf), .state(state), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 count, 2 drain, 3 done.
    int m_cnt [NC];
    int m_ovf [NC];
    int m_shd [NC];
    int m_shdo[NC];
    int m_ph;
    int m_left;
    bit m_sv;

    always @(posedge clk or posedge rst) begin
        int nc[NC];
        int no[NC];
        bit [NC-1:0] evs;
        bit ent;
        bit live;
        if (rst) begin
            m_ph = 0; m_left = 0; m_sv = 0;
            for (int i = 0; i < NC; i++) begin
                m_cnt[i] = 0; m_ovf[i] = 0; m_shd[i] = 0; m_shdo[i] = 0;
            end
        end else begin
            evs  = {1'b1, event_in};
            live = (m_ph == 1) || (m_ph == 2);
            for (int i = 0; i < NC; i++) begin
                nc[i] = m_cnt[i];
                no[i] = m_ovf[i];
                if (live && evs[i]) begin
                    if (m_cnt[i] + 1 > MAXV) begin
                        no[i] = 1;
                        nc[i] = WRAP ? (m_cnt[i] + 1) % (MAXV + 1) : MAXV;
                    end else begin
                        nc[i] = m_cnt[i] + 1;
                    end
                end
            end
            ent = 0;
            if (clear) begin
                if (m_ph == 3) m_ph = 0;
            end else begin
                case (m_ph)
                    0: if (start) m_ph = 1;
                    1: if (halt_seen) begin m_ph = 2; m_left = PD; end
                    2: begin
                        m_left--;
                        if (m_left == 0) begin m_ph = 3; ent = 1; end
                    end
                    default: ;
                endcase
            end
            if (clear) begin
                m_sv = 0;
                for (int i = 0; i < NC; i++) begin
                    nc[i] = 0; no[i] = 0; m_shd[i] = 0; m_shdo[i] = 0;
                end
            end else if (rd_ack) begin
                m_sv = 0;
            end else if (!m_sv && ent) begin
                m_sv = 1;
                for (int i = 0; i < NC; i++) begin
                    m_shd[i] = nc[i]; m_shdo[i] = no[i];
                end
            end else if (!m_sv && snap_req) begin
                m_sv = 1;
                for (int i = 0; i < NC; i++) begin
                    m_shd[i] = m_cnt[i]; m_shdo[i] = m_ovf[i];
                end
            end
            for (int i = 0; i < NC; i++) begin
                m_cnt[i] = nc[i]; m_ovf[i] = no[i];
            end
        end
    end

    always @(negedge clk) begin
        int ed;
        int eo;
        if (en_cmp && !rst) begin
            ed = (rd_sel <= NE) ? m_shd[rd_sel]  : 0;
            eo = (rd_sel <= NE) ? m_shdo[rd_sel] : 0;
            check("m_state", state, m_ph);
            check("m_done", done, (m_ph == 3));
            check("m_snap_valid", snap_valid, m_sv);
            check("m_rd_data", rd_data, ed);
            check("m_rd_ovf", rd_ovf, eo);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        #12;
        check("rst_state", state, 0);
        check("rst_done", done, 0);
        check("rst_snap_valid", snap_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_ovf", rd_ovf, 0);
        tick();
        rst = 1'b0;
        en_cmp = 1'b1;

        start = 1; tick(); start = 0;
        check("start_state", state, 1);
        event_in = 6'b000001;
        repeat (10) tick();
        event_in = '0;
        snap_req = 1; tick(); snap_req = 0;
        check("snap_valid_set", snap_valid, 1);
        rd_sel = 0; #1 check("snap_ev0", rd_data, 10);
        rd_sel = 6; #1 check("snap_cyc", rd_data, 10);

        snap_req = 1; tick(); snap_req = 0;
        #1 check("snap_hold", rd_data, 10);
        rd_ack = 1; tick(); rd_ack = 0;
        check("ack_clears", snap_valid, 0);
        snap_req = 1; tick(); snap_req = 0;
        #1 check("snap_new_cyc", rd_data, 13);
        rd_ack = 1; tick(); rd_ack = 0;

        event_in = 6'b000100;
        repeat (7) tick();
        clear = 1; tick(); clear = 0;
        event_in = '0;
        check("clear_keeps_state", state, 1);
        snap_req = 1; tick(); snap_req = 0;
        rd_sel = 2; #1 check("clear_wins_ev2", rd_data, 0);
        rd_sel = 6; #1 check("clear_cyc", rd_data, 0);
        rd_ack = 1; tick(); rd_ack = 0;

        clear = 1; tick(); clear = 0;
        event_in = 6'b000010;
        repeat (300) tick();
        event_in = '0;
        snap_req = 1; tick(); snap_req = 0;
        rd_sel = 1;
        #1 check("sat_data", rd_data, WRAP ? 44 : 255);
        check("sat_ovf", rd_ovf, 1);
        rd_sel = 2; #1 check("sat_other_ovf", rd_ovf, 0);
        rd_sel = 7; #1 check("sel_oob", rd_data, 0);
        rd_ack = 1; tick(); rd_ack = 0;

        event_in = 6'b000001;
        halt_seen = 1; tick();
        check("drain_entry", state, 2);
        n = 0;
        while (state == 2 && n < 20) begin
            n++;
            tick();
        end
        halt_seen = 0;
        check("drain_len", n, PD);
        check("done_state", state, 3);
        check("done_flag", done, 1);
        check("auto_snap", snap_valid, 1);
        rd_sel = 0; #1 check("auto_snap_ev0", rd_data, 6);
        repeat (3) tick();
        rd_ack = 1; tick(); rd_ack = 0;
        snap_req = 1; tick(); snap_req = 0;
        event_in = '0;
        #1 check("frozen_ev0", rd_data, 6);
        start = 1; tick(); start = 0;
        check("done_ignores_start", state, 3);
        clear = 1; tick(); clear = 0;
        check("clear_done_state", state, 0);
        check("clear_done_flag", done, 0);
        check("clear_done_sv", snap_valid, 0);

        start = 1; tick(); start = 0;
        snap_req = 1; tick(); snap_req = 0;
        halt_seen = 1; tick(); halt_seen = 0;
        tick();
        check("pre_rst_drain", state, 2);
        check("pre_rst_sv", snap_valid, 1);
        #1 rst = 1;
        #1;
        check("arst_state", state, 0);
        check("arst_done", done, 0);
        check("arst_sv", snap_valid, 0);
        check("arst_rd_data", rd_data, 0);
        tick();
        rst = 0;

        for (int c = 0; c < 3000; c++) begin
            start     = ($urandom % 8) == 0;
            clear     = ($urandom % 40) == 0;
            halt_seen = ($urandom % 30) == 0;
            snap_req  = ($urandom % 6) == 0;
            rd_ack    = ($urandom % 5) == 0;
            event_in  = NE'($urandom);
            rd_sel    = SW'($urandom_range(0, 7));
            tick();
        end
        start = 0; clear = 0; halt_seen = 0;
        snap_req = 0; rd_ack = 0; event_in = '0;
        tick();
        en_cmp = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_monitor_unit.md
Name: perf_monitor_unit

Overview:
Parametrised successor to the CPU's fixed performance-counter and done logic. Provides NUM_EVENTS event counters plus a cycle counter, each with a sticky overflow bit. Offers a snapshot/read handshake for consistent readout. Replaces the hard-coded instruction-count "done" test with halt-driven pipeline-drain detection. Sits beside the 5-stage pipeline; event bits are driven from pipeline-register control fields.

Parameters:
NUM_EVENTS, 6, number of event counters (2..16); index NUM_EVENTS addresses the cycle counter
CNT_W, 32, counter width in bits (8..64)
PIPE_DEPTH, 5, cycles from halt detection to pipeline empty (>=1)
SEL_W, $clog2(NUM_EVENTS+1), read-select width; derived, not overridden

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
start  in  1  pulse: begin counting (accepted in IDLE only)
clear  in  1  synchronous clear of counters, overflow bits and snapshot
event_in  in  NUM_EVENTS  per-cycle event strobes, bit i -> counter i
halt_seen  in  1  halt instruction reached EX/MEM; begins drain
snap_req  in  1  pulse: request snapshot of all counters
snap_valid  out  1  shadow registers hold a stable snapshot
rd_ack  in  1  reader finished; releases snapshot
rd_sel  in  SEL_W  shadow counter select
rd_data  out  CNT_W  selected shadow counter value
rd_ovf  out  1  selected shadow overflow bit
state  out  2  00 IDLE, 01 COUNT, 10 DRAIN, 11 DONE
done  out  1  high in DONE

Behaviour:
- Reset: state=IDLE; done=0; snap_valid=0; all counters, shadows and overflow bits 0; rd_data=0; rd_ovf=0.
- IDLE: counters hold. start -> COUNT on the next edge. halt_seen is ignored.
- COUNT: cycle counter +1 every cycle. Counter i +1 in each cycle event_in[i]=1. halt_seen -> DRAIN; drain counter loads PIPE_DEPTH-1.
- DRAIN: counting continues. Drain counter decrements each cycle. At drain counter=0 -> DONE on the next edge. For PIPE_DEPTH=1, DONE is reached exactly 1 cycle after halt_seen. halt_seen in DRAIN is ignored and does not restart the drain.
- DONE: all counters frozen; done=1. An automatic snapshot is taken on entry if snap_valid=0. start is ignored.
- Counter arithmetic:
  - Default is saturate at 2^CNT_W-1.
  - An increment attempted at all-ones sets that counter's sticky overflow bit.
  - Overflow bits clear only on clear or rst.
- clear:
  - Zeroes counters, overflow bits, shadows and snap_valid.
  - If state=DONE, clear moves state to IDLE; otherwise state is unchanged.
  - clear wins over a same-cycle event: counter result = 0.
- Snapshot:
  - snap_req with snap_valid=0 copies all registered counter values and overflow bits into the shadows; these are pre-increment values of that cycle.
  - snap_valid=1 from the next edge.
  - snap_req while snap_valid=1 is ignored.
  - rd_ack clears snap_valid on the next edge.
  - snap_req and rd_ack in the same cycle: the ack is processed, the request is dropped.
  - snap_req and clear in the same cycle: clear wins, snap_valid=0.
- Readout: rd_data/rd_ovf are combinational from the shadows via rd_sel. rd_sel > NUM_EVENTS returns 0/0.
- Reset mid-operation: immediate return to reset values regardless of state.

Optional Feature:
PMU_WRAP_EN:
- Defined: counters wrap modulo 2^CNT_W instead of saturating; the overflow bit is still set on each wrap.
- Undefined: saturating behaviour as above.

Test Plan:
- Reset, start, event_in[0]=1 for 10 cycles, snap_req -> snap_valid next cycle; rd_sel=0 gives 10; rd_sel=6 gives cycle count 10 (+1 per extra idle cycle before snap_req).
- CNT_W=8, event_in[1] held 300 cycles -> rd_data=255, rd_ovf=1. With PMU_WRAP_EN -> rd_data=44 (300 mod 256), rd_ovf=1.
- halt_seen in COUNT with PIPE_DEPTH=5 -> state DRAIN for 5 cycles, done=1 on the 5th edge after halt. Counters frozen afterwards; auto-snapshot gives snap_valid=1.
- snap_req, then a second snap_req before rd_ack -> shadow unchanged. After rd_ack, a new snap_req captures updated values.
- clear in the same cycle as event_in[2]=1 with counter 2 at 7 -> counter 2 = 0. From DONE, clear gives state=IDLE, done=0.
- rst asserted asynchronously during DRAIN -> state=IDLE, done=0, snap_valid=0 without waiting for a clock edge.
